// File: rtl/jtdsp16_sio_rx_if.sv
// DSP16 serial output link (ock/sdo/old/sadd/doen) plus the stereo pair and status it produces.
// JTDSP16_SIORX_STATS_EN adds the word/error debug counters to the bundle.
interface jtdsp16_sio_rx_if;
  logic        ock;
  logic        sdo;
  logic        old;
  logic        sadd;
  logic        doen;
  logic [15:0] left;
  logic [15:0] right;
  logic        pair_valid;
  logic        sync_err;
  logic        overrun;
`ifdef JTDSP16_SIORX_STATS_EN
  logic [15:0] debug_words;
  logic [7:0]  debug_errs;
`endif

  modport master (
    output ock, sdo, old, sadd,
`ifdef JTDSP16_SIORX_STATS_EN
    input  debug_words, debug_errs,
`endif
    input  doen, left, right, pair_valid, sync_err, overrun
  );

  modport slave (
    input  ock, sdo, old, sadd,
`ifdef JTDSP16_SIORX_STATS_EN
    output debug_words, debug_errs,
`endif
    output doen, left, right, pair_valid, sync_err, overrun
  );
endinterface

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial output receiver: deserialises old-framed words into left/right samples (JTDSP16_SIORX_STATS_EN adds counters).
// Latency: sample updates one clk after the cen cycle that sees the last ock rising edge.
// Backpressure: none; the DSP is never stalled (doen held active), a new word simply overwrites.
module jtdsp16_sio_rx #(
  parameter int WORD_LEN  = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit LEFT_SADD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  jtdsp16_sio_rx_if.slave sio
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t              state, state_nxt;
  logic                ock_reg, ock_prev, old_reg, old_prev, sdo_reg, sadd_reg;
  logic                ock_rise, old_rise;
  logic [4:0]          cnt;
  logic                last_bit;
  logic                chan_left;
  logic                have_left;
  logic [WORD_LEN-1:0] shreg, shift_nxt;
  logic [15:0]         word16;
  logic                latch_chan, shift_en, commit, frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      ock_reg  <= 1'b0;
      ock_prev <= 1'b0;
      old_reg  <= 1'b0;
      old_prev <= 1'b0;
      sdo_reg  <= 1'b0;
      sadd_reg <= 1'b0;
    end else if (cen) begin
      ock_reg  <= sio.ock;
      ock_prev <= ock_reg;
      old_reg  <= sio.old;
      old_prev <= old_reg;
      sdo_reg  <= sio.sdo;
      sadd_reg <= sio.sadd;
    end
  end

  assign ock_rise = cen & ock_reg & ~ock_prev;
  assign old_rise = cen & old_reg & ~old_prev;
  assign last_bit = (cnt == 5'(WORD_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A word-start edge always wins over a coincident ock edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (old_rise) state_nxt = ARMED;
      ARMED:   if (old_rise) state_nxt = ARMED;
               else if (ock_rise) state_nxt = SHIFT;
      SHIFT:   if (old_rise) state_nxt = ARMED;
               else if (ock_rise && last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_chan = old_rise;
    frame_err  = old_rise && (state != IDLE);
    shift_en   = ock_rise && !old_rise && (state != IDLE);
    commit     = shift_en && (state == SHIFT) && last_bit;
    sio.doen   = 1'b0;
  end

  always_comb begin
    if (MSB_FIRST) shift_nxt = {shreg[WORD_LEN-2:0], sdo_reg};
    else           shift_nxt = {sdo_reg, shreg[WORD_LEN-1:1]};
  end

  // Short words sit in the top of the 16-bit sample.
  assign word16 = 16'(shift_nxt) << (16 - WORD_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= 5'd0;
      shreg          <= '0;
      chan_left      <= 1'b0;
      have_left      <= 1'b0;
      sio.left       <= 16'd0;
      sio.right      <= 16'd0;
      sio.pair_valid <= 1'b0;
      sio.sync_err   <= 1'b0;
      sio.overrun    <= 1'b0;
    end else begin
      sio.pair_valid <= 1'b0;
      sio.sync_err   <= frame_err;
      if (latch_chan) begin
        chan_left <= (sadd_reg == LEFT_SADD);
        cnt       <= 5'd0;
        shreg     <= '0;
      end
      if (shift_en) begin
        shreg <= shift_nxt;
        cnt   <= commit ? 5'd0 : cnt + 5'd1;
      end
      if (commit) begin
        if (chan_left) begin
          sio.left  <= word16;
          have_left <= 1'b1;
          if (have_left) sio.overrun <= 1'b1;
        end else begin
          sio.right <= word16;
          have_left <= 1'b0;
          if (have_left) sio.pair_valid <= 1'b1;
        end
      end
    end
  end

`ifdef JTDSP16_SIORX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sio.debug_words <= 16'd0;
      sio.debug_errs  <= 8'd0;
    end else begin
      if (commit) sio.debug_words <= sio.debug_words + 16'd1;
      if (frame_err && sio.debug_errs != 8'hFF) sio.debug_errs <= sio.debug_errs + 8'd1;
    end
  end
`endif

endmodule
